// File: rtl/decode_queue.sv
// decode_queue: DEPTH-entry instruction/PC FIFO feeding an RV32I full decoder
// whose result sits in a registered output stage with a valid/ready handshake.
//
// Ports:
//   clock, reset_n         rising-edge clock, asynchronous active-low reset
//   flush                  synchronous; empties FIFO and output stage
//   fetch_valid/_ready     fetch-side handshake (no same-cycle pop credit)
//   fetch_instr, fetch_pc  raw instruction and its PC
//   issue_valid/_ready     issue-side handshake toward ROB/RS
//   op_type .. illegal     registered decoded fields of the presented entry
//   pc                     PC of the presented instruction
//   count                  FIFO occupancy, output register excluded
module decode_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             fetch_valid,
    output logic             fetch_ready,
    input  logic [31:0]      fetch_instr,
    input  logic [31:0]      fetch_pc,
    output logic             issue_valid,
    input  logic             issue_ready,
    output logic [6:0]       op_type,
    output logic [2:0]       op_sub,
    output logic             op_flag,
    output logic [31:0]      imm,
    output logic [31:0]      pc,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [4:0]       rd,
    output logic             use_rs1,
    output logic             use_rs2,
    output logic             writes_rd,
    output logic             illegal,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    typedef struct packed {
        logic [6:0]  op_type;
        logic [2:0]  op_sub;
        logic        op_flag;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        use_rs1;
        logic        use_rs2;
        logic        writes_rd;
        logic        illegal;
    } dec_t;

    // Full RV32I decode of one instruction word; unused fields stay 0.
    function automatic dec_t decode(input logic [31:0] instr);
        dec_t d;
        d         = '0;
        d.op_type = instr[6:0];
        case (instr[6:0])
            OPC_LUI, OPC_AUIPC: begin
                d.rd        = instr[11:7];
                d.writes_rd = 1'b1;
                d.imm       = {instr[31:12], 12'b0};
            end
            OPC_JAL: begin
                d.rd        = instr[11:7];
                d.writes_rd = 1'b1;
                d.imm       = {{11{instr[31]}}, instr[31], instr[19:12],
                               instr[20], instr[30:21], 1'b0};
            end
            OPC_JALR, OPC_LOAD: begin
                d.rd        = instr[11:7];
                d.rs1       = instr[19:15];
                d.op_sub    = instr[14:12];
                d.writes_rd = 1'b1;
                d.use_rs1   = 1'b1;
                d.imm       = {{20{instr[31]}}, instr[31:20]};
            end
            OPC_BRANCH: begin
                d.rs1     = instr[19:15];
                d.rs2     = instr[24:20];
                d.op_sub  = instr[14:12];
                d.use_rs1 = 1'b1;
                d.use_rs2 = 1'b1;
                d.imm     = {{19{instr[31]}}, instr[31], instr[7],
                             instr[30:25], instr[11:8], 1'b0};
            end
            OPC_STORE: begin
                d.rs1     = instr[19:15];
                d.rs2     = instr[24:20];
                d.op_sub  = instr[14:12];
                d.use_rs1 = 1'b1;
                d.use_rs2 = 1'b1;
                d.imm     = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OPC_OPIMM: begin
                d.rd        = instr[11:7];
                d.rs1       = instr[19:15];
                d.op_sub    = instr[14:12];
                d.writes_rd = 1'b1;
                d.use_rs1   = 1'b1;
                d.imm       = {{20{instr[31]}}, instr[31:20]};
                // Shifts carry a zero-extended shamt and funct7 qualifies them
                if (instr[14:12] == 3'b001) begin
                    d.imm     = {27'b0, instr[24:20]};
                    d.op_flag = instr[30];
                    d.illegal = (instr[31:25] != 7'b0000000);
                end else if (instr[14:12] == 3'b101) begin
                    d.imm     = {27'b0, instr[24:20]};
                    d.op_flag = instr[30];
                    d.illegal = (instr[31:25] != 7'b0000000) &&
                                (instr[31:25] != 7'b0100000);
                end
            end
            OPC_OP: begin
                d.rd        = instr[11:7];
                d.rs1       = instr[19:15];
                d.rs2       = instr[24:20];
                d.op_sub    = instr[14:12];
                d.op_flag   = instr[30];
                d.writes_rd = 1'b1;
                d.use_rs1   = 1'b1;
                d.use_rs2   = 1'b1;
            end
            OPC_FENCE: begin
                d.op_sub = instr[14:12];
                d.imm    = {24'b0, instr[27:20]};
            end
            default: begin
                d.illegal = 1'b1;
            end
        endcase
        return d;
    endfunction

    // FIFO storage and control
    logic [31:0]      instr_mem_q [DEPTH];
    logic [31:0]      pc_mem_q    [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Output stage
    logic             valid_q, valid_d;
    dec_t             dec_q, dec_d;
    logic [31:0]      pc_q, pc_d;

    logic             fetch_ready_c;
    logic             push_c;
    logic             pop_c;
    logic             load_c;
    logic             empty_c;
    dec_t             head_dec_c;

    assign empty_c       = (count_q == '0);
    assign fetch_ready_c = reset_n && (count_q < CNT_W'(DEPTH));
    assign push_c        = fetch_valid && fetch_ready_c && !flush;
    assign load_c        = !valid_q || issue_ready;
    assign pop_c         = load_c && !empty_c && !flush;
    assign head_dec_c    = decode(instr_mem_q[rd_ptr_q]);

    // Next-state for pointers, occupancy and the output stage
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        valid_d  = valid_q;
        dec_d    = dec_q;
        pc_d     = pc_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            valid_d  = 1'b0;
            dec_d    = '0;
            pc_d     = '0;
        end else begin
            if (push_c) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push_c, pop_c})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            // An empty FIFO on a load slot leaves the fields but drops valid
            if (load_c) begin
                if (!empty_c) begin
                    valid_d = 1'b1;
                    dec_d   = head_dec_c;
                    pc_d    = pc_mem_q[rd_ptr_q];
                end else begin
                    valid_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            dec_q    <= '0;
            pc_q     <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            dec_q    <= dec_d;
            pc_q     <= pc_d;
        end
    end

    // Payload storage needs no reset; occupancy gates every read
    always_ff @(posedge clock) begin
        if (push_c) begin
            instr_mem_q[wr_ptr_q] <= fetch_instr;
            pc_mem_q[wr_ptr_q]    <= fetch_pc;
        end
    end

    assign fetch_ready = fetch_ready_c;
    assign issue_valid = valid_q;
    assign op_type     = dec_q.op_type;
    assign op_sub      = dec_q.op_sub;
    assign op_flag     = dec_q.op_flag;
    assign imm         = dec_q.imm;
    assign pc          = pc_q;
    assign rs1         = dec_q.rs1;
    assign rs2         = dec_q.rs2;
    assign rd          = dec_q.rd;
    assign use_rs1     = dec_q.use_rs1;
    assign use_rs2     = dec_q.use_rs2;
    assign writes_rd   = dec_q.writes_rd;
    assign illegal     = dec_q.illegal;
    assign count       = count_q;

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: table of decode vectors plus hand-written
// sequences for backpressure, streaming, async reset and flush.
module tb_decode_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             flush;
    logic             fetch_valid;
    logic             fetch_ready;
    logic [31:0]      fetch_instr;
    logic [31:0]      fetch_pc;
    logic             issue_valid;
    logic             issue_ready;
    logic [6:0]       op_type;
    logic [2:0]       op_sub;
    logic             op_flag;
    logic [31:0]      imm;
    logic [31:0]      pc;
    logic [4:0]       rs1, rs2, rd;
    logic             use_rs1, use_rs2, writes_rd, illegal;
    logic [CNT_W-1:0] count;

    decode_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .flush       (flush),
        .fetch_valid (fetch_valid),
        .fetch_ready (fetch_ready),
        .fetch_instr (fetch_instr),
        .fetch_pc    (fetch_pc),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .op_type     (op_type),
        .op_sub      (op_sub),
        .op_flag     (op_flag),
        .imm         (imm),
        .pc          (pc),
        .rs1         (rs1),
        .rs2         (rs2),
        .rd          (rd),
        .use_rs1     (use_rs1),
        .use_rs2     (use_rs2),
        .writes_rd   (writes_rd),
        .illegal     (illegal),
        .count       (count)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [6:0]  op_type;
        logic [2:0]  op_sub;
        logic        op_flag;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        use_rs1;
        logic        use_rs2;
        logic        writes_rd;
        logic        illegal;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs [NVEC];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] addi_k(input int k);
        logic [11:0] k12;
        k12 = 12'(k);
        return {k12, 20'h00093};
    endfunction

    initial begin
        int accepted;
        int k;
        bit acc_now;

        //            instr         pc            opc    f3    fl    imm           rs1    rs2    rd     u1 u2 wr il
        vecs[0]  = '{32'hFE208EE3, 32'h00000100, 7'h63, 3'd0, 1'b0, 32'hFFFFFFFC, 5'd1,  5'd2,  5'd0,  1, 1, 0, 0};
        vecs[1]  = '{32'h40335293, 32'h00001004, 7'h13, 3'd5, 1'b1, 32'h00000003, 5'd6,  5'd0,  5'd5,  1, 0, 1, 0};
        vecs[2]  = '{32'h008000EF, 32'h00001008, 7'h6F, 3'd0, 1'b0, 32'h00000008, 5'd0,  5'd0,  5'd1,  0, 0, 1, 0};
        vecs[3]  = '{32'h123451B7, 32'h0000100C, 7'h37, 3'd0, 1'b0, 32'h12345000, 5'd0,  5'd0,  5'd3,  0, 0, 1, 0};
        vecs[4]  = '{32'hFFFFF297, 32'h00001010, 7'h17, 3'd0, 1'b0, 32'hFFFFF000, 5'd0,  5'd0,  5'd5,  0, 0, 1, 0};
        vecs[5]  = '{32'hFF812383, 32'h00001014, 7'h03, 3'd2, 1'b0, 32'hFFFFFFF8, 5'd2,  5'd0,  5'd7,  1, 0, 1, 0};
        vecs[6]  = '{32'h00922A23, 32'h00001018, 7'h23, 3'd2, 1'b0, 32'h00000014, 5'd4,  5'd9,  5'd0,  1, 1, 0, 0};
        vecs[7]  = '{32'hFE110FA3, 32'h0000101C, 7'h23, 3'd0, 1'b0, 32'hFFFFFFFF, 5'd2,  5'd1,  5'd0,  1, 1, 0, 0};
        vecs[8]  = '{32'h40C58533, 32'h00001020, 7'h33, 3'd0, 1'b1, 32'h00000000, 5'd11, 5'd12, 5'd10, 1, 1, 1, 0};
        vecs[9]  = '{32'h0FF0000F, 32'h00001024, 7'h0F, 3'd0, 1'b0, 32'h000000FF, 5'd0,  5'd0,  5'd0,  0, 0, 0, 0};
        vecs[10] = '{32'h010280E7, 32'h00001028, 7'h67, 3'd0, 1'b0, 32'h00000010, 5'd5,  5'd0,  5'd1,  1, 0, 1, 0};
        vecs[11] = '{32'hFFF00093, 32'h0000102C, 7'h13, 3'd0, 1'b0, 32'hFFFFFFFF, 5'd0,  5'd0,  5'd1,  1, 0, 1, 0};
        vecs[12] = '{32'h01F15093, 32'h00001030, 7'h13, 3'd5, 1'b0, 32'h0000001F, 5'd2,  5'd0,  5'd1,  1, 0, 1, 0};
        vecs[13] = '{32'h0000007F, 32'h00001034, 7'h7F, 3'd0, 1'b0, 32'h00000000, 5'd0,  5'd0,  5'd0,  0, 0, 0, 1};
        vecs[14] = '{32'h02001013, 32'h00001038, 7'h13, 3'd1, 1'b0, 32'h00000000, 5'd0,  5'd0,  5'd0,  1, 0, 1, 1};
        vecs[15] = '{32'h6020D093, 32'h0000103C, 7'h13, 3'd5, 1'b1, 32'h00000002, 5'd1,  5'd0,  5'd1,  1, 0, 1, 1};

        reset_n     = 1'b0;
        flush       = 1'b0;
        fetch_valid = 1'b0;
        fetch_instr = '0;
        fetch_pc    = '0;
        issue_ready = 1'b0;

        // Reset state
        #2;
        chk("rst.issue_valid", 32'(issue_valid), 32'd0);
        chk("rst.count",       32'(count),       32'd0);
        chk("rst.fetch_ready", 32'(fetch_ready), 32'd0);
        chk("rst.imm",         imm,              32'd0);
        chk("rst.op_type",     32'(op_type),     32'd0);
        @(posedge clock);
        #2 reset_n = 1'b1;
        #1;
        chk("rel.fetch_ready", 32'(fetch_ready), 32'd1);
        tick();

        // Table-driven decode: push one, present it, check every field
        issue_ready = 1'b1;
        for (int i = 0; i < NVEC; i++) begin
            fetch_valid = 1'b1;
            fetch_instr = vecs[i].instr;
            fetch_pc    = vecs[i].pc;
            tick();
            fetch_valid = 1'b0;
            tick();
            chk($sformatf("v%0d.valid", i),     32'(issue_valid), 32'd1);
            chk($sformatf("v%0d.count", i),     32'(count),       32'd0);
            chk($sformatf("v%0d.op_type", i),   32'(op_type),     32'(vecs[i].op_type));
            chk($sformatf("v%0d.op_sub", i),    32'(op_sub),      32'(vecs[i].op_sub));
            chk($sformatf("v%0d.op_flag", i),   32'(op_flag),     32'(vecs[i].op_flag));
            chk($sformatf("v%0d.imm", i),       imm,              vecs[i].imm);
            chk($sformatf("v%0d.pc", i),        pc,               vecs[i].pc);
            chk($sformatf("v%0d.rs1", i),       32'(rs1),         32'(vecs[i].rs1));
            chk($sformatf("v%0d.rs2", i),       32'(rs2),         32'(vecs[i].rs2));
            chk($sformatf("v%0d.rd", i),        32'(rd),          32'(vecs[i].rd));
            chk($sformatf("v%0d.use_rs1", i),   32'(use_rs1),     32'(vecs[i].use_rs1));
            chk($sformatf("v%0d.use_rs2", i),   32'(use_rs2),     32'(vecs[i].use_rs2));
            chk($sformatf("v%0d.writes_rd", i), 32'(writes_rd),   32'(vecs[i].writes_rd));
            chk($sformatf("v%0d.illegal", i),   32'(illegal),     32'(vecs[i].illegal));
        end
        tick();
        chk("idle.valid", 32'(issue_valid), 32'd0);

        // Backpressure: 1 in output stage + DEPTH in FIFO
        issue_ready = 1'b0;
        accepted    = 0;
        k           = 1;
        fetch_valid = 1'b1;
        fetch_instr = addi_k(k);
        fetch_pc    = 32'h200 + 32'(4 * k);
        for (int n = 0; n < 7; n++) begin
            acc_now = fetch_ready;
            tick();
            if (acc_now) begin
                accepted++;
                k++;
                fetch_instr = addi_k(k);
                fetch_pc    = 32'h200 + 32'(4 * k);
            end
        end
        chk("bp.accepted",    32'(accepted),    32'd5);
        chk("bp.count",       32'(count),       32'd4);
        chk("bp.fetch_ready", 32'(fetch_ready), 32'd0);
        chk("bp.valid",       32'(issue_valid), 32'd1);
        chk("bp.imm",         imm,              32'd1);
        chk("bp.pc",          pc,               32'h204);
        tick();
        chk("bp.hold_imm",    imm,              32'd1);
        chk("bp.hold_pc",     pc,               32'h204);
        chk("bp.hold_rd",     32'(rd),          32'd1);
        fetch_valid = 1'b0;
        issue_ready = 1'b1;
        for (int j = 2; j <= 5; j++) begin
            tick();
            chk($sformatf("drain%0d.valid", j), 32'(issue_valid), 32'd1);
            chk($sformatf("drain%0d.imm", j),   imm,              32'(j));
            chk($sformatf("drain%0d.pc", j),    pc,               32'h200 + 32'(4 * j));
            chk($sformatf("drain%0d.count", j), 32'(count),       32'(5 - j));
        end
        tick();
        chk("drain.empty_valid", 32'(issue_valid), 32'd0);

        // Streaming: push and pop every cycle, occupancy steady at 1
        issue_ready = 1'b1;
        fetch_valid = 1'b1;
        for (int n = 0; n < 6; n++) begin
            fetch_instr = addi_k(32'h40 + n);
            fetch_pc    = 32'h400 + 32'(4 * n);
            tick();
            if (n >= 1) begin
                chk($sformatf("st%0d.count", n), 32'(count),       32'd1);
                chk($sformatf("st%0d.valid", n), 32'(issue_valid), 32'd1);
                chk($sformatf("st%0d.imm", n),   imm,              32'(32'h40 + n - 1));
                chk($sformatf("st%0d.pc", n),    pc,               32'h400 + 32'(4 * (n - 1)));
            end
        end
        fetch_valid = 1'b0;
        tick();
        chk("st.last_imm",   imm,              32'h45);
        chk("st.last_count", 32'(count),       32'd0);
        tick();
        chk("st.idle_valid", 32'(issue_valid), 32'd0);

        // Asynchronous reset with entries queued and presented
        issue_ready = 1'b0;
        fetch_valid = 1'b1;
        for (int n = 0; n < 3; n++) begin
            fetch_instr = addi_k(32'h60 + n);
            fetch_pc    = 32'h500 + 32'(4 * n);
            tick();
        end
        fetch_valid = 1'b0;
        chk("pre_rst.count", 32'(count),       32'd2);
        chk("pre_rst.valid", 32'(issue_valid), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        chk("arst.count",       32'(count),       32'd0);
        chk("arst.valid",       32'(issue_valid), 32'd0);
        chk("arst.fetch_ready", 32'(fetch_ready), 32'd0);
        chk("arst.imm",         imm,              32'd0);
        chk("arst.pc",          pc,               32'd0);
        chk("arst.rd",          32'(rd),          32'd0);
        chk("arst.writes_rd",   32'(writes_rd),   32'd0);
        #1 reset_n = 1'b1;
        #1;
        chk("arst.rel_ready", 32'(fetch_ready), 32'd1);
        tick();
        chk("arst.post_valid", 32'(issue_valid), 32'd0);

        // Flush with FIFO full, entry presented and a same-cycle push
        issue_ready = 1'b0;
        fetch_valid = 1'b1;
        for (int n = 0; n < 6; n++) begin
            fetch_instr = addi_k(32'h70 + n);
            fetch_pc    = 32'h600 + 32'(4 * n);
            tick();
        end
        chk("pre_fl.count", 32'(count),       32'd4);
        chk("pre_fl.valid", 32'(issue_valid), 32'd1);
        fetch_instr = 32'h7AB00093;
        fetch_pc    = 32'h6F0;
        flush       = 1'b1;
        issue_ready = 1'b1;
        tick();
        flush       = 1'b0;
        fetch_valid = 1'b0;
        chk("fl.count",       32'(count),       32'd0);
        chk("fl.valid",       32'(issue_valid), 32'd0);
        chk("fl.fetch_ready", 32'(fetch_ready), 32'd1);
        for (int n = 0; n < 3; n++) begin
            tick();
            chk($sformatf("fl.after%0d_valid", n), 32'(issue_valid), 32'd0);
        end
        fetch_valid = 1'b1;
        fetch_instr = addi_k(32'h55);
        fetch_pc    = 32'h300;
        tick();
        fetch_valid = 1'b0;
        tick();
        chk("fl.next_valid", 32'(issue_valid), 32'd1);
        chk("fl.next_imm",   imm,              32'h55);
        chk("fl.next_pc",    pc,               32'h300);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decode_queue.md
# decode_queue

Parametrised successor to the single-instruction decoder. It buffers fetched RV32I instructions with their PCs in a DEPTH-entry FIFO and fully decodes the head, including all immediate formats and illegal-opcode detection. The decoded result is held in a registered output stage with a valid/ready handshake toward ROB issue and the reservation stations. It sits between instruction fetch and the ROB/register-status issue logic, and supports a pipeline flush for branch mispredicts.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2; excludes the output register
- CNT_W, $clog2(DEPTH)+1, width of `count`
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous; empties FIFO and output stage
- fetch_valid  in  1  fetch offers an instruction
- fetch_ready  out  1  FIFO can accept
- fetch_instr  in  32  raw instruction
- fetch_pc  in  32  instruction PC
- issue_valid  out  1  decoded instruction presented
- issue_ready  in  1  ROB and RS both have room
- op_type  out  7  instr[6:0]
- op_sub  out  3  funct3, or 0 when the format has none
- op_flag  out  1  instr[30] for OP and OP-IMM shifts, else 0
- imm  out  32  sign-extended immediate, or 0
- pc  out  32  PC of the presented instruction
- rs1, rs2, rd  out  5 each  register fields, 0 when unused
- use_rs1, use_rs2, writes_rd  out  1 each  field-valid flags
- illegal  out  1  unsupported encoding
- count  out  CNT_W  FIFO occupancy, excluding the output register

## Operation
- Push: an entry is accepted when fetch_valid && fetch_ready && !flush at a clock edge.
- fetch_ready = reset_n && (count < DEPTH). There is no same-cycle pop credit.
- Output stage load: the output stage loads the decoded FIFO head when `!issue_valid || issue_ready` and the FIFO is non-empty. The head pops on the same edge.
- If the FIFO is empty on a load condition, issue_valid drops to 0.
- Hold: while issue_valid && !issue_ready, every issue output stays stable.
- Flush has the highest priority. At the edge it empties the FIFO, clears issue_valid and drops any same-cycle push.
- Decode by opcode:
  - LUI 0110111 and AUIPC 0010111: rd; imm = {instr[31:12], 12'b0}.
  - JAL 1101111: rd; imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - JALR 1100111: rd, rs1, funct3; I-imm = sext(instr[31:20]).
  - BRANCH 1100011: rs1, rs2, funct3; imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - LOAD 0000011: rd, rs1, funct3; I-imm.
  - STORE 0100011: rs1, rs2, funct3; imm = sext({instr[31:25], instr[11:7]}).
  - OP-IMM 0010011: rd, rs1, funct3; I-imm. For funct3 001/101: imm = {27'b0, instr[24:20]} and op_flag = instr[30].
  - OP 0110011: rd, rs1, rs2, funct3; op_flag = instr[30].
  - FENCE 0001111: funct3; imm = {24'b0, instr[27:20]}.
- Illegal encodings:
  - Any other opcode: illegal = 1, op_type passed through, all other fields 0.
  - SLLI with instr[31:25] ≠ 0, or SRLI/SRAI with instr[31:25] ∉ {0000000, 0100000}: illegal = 1.
- An illegal instruction still issues normally; the ROB raises the exception.

## Timing
- Reset values: issue_valid 0, count 0, fetch_ready 0 while reset_n is low, and every decoded output 0. fetch_ready rises in the first cycle after reset release.
- Reset mid-operation discards all queued and presented entries immediately (asynchronous).
- Latency: an instruction accepted at edge E is presented (issue_valid = 1) after edge E+1 when the path is empty. Throughput is one per cycle.
- Simultaneous push and pop with the FIFO not full: count is unchanged. At full, no push is possible, so a pop reduces count by 1.
- Pointers wrap modulo DEPTH; count distinguishes full from empty.
- Ordering is strict FIFO. pc always travels with its own instruction.

## Test plan
- Reset: load 3 entries, pulse reset_n low between edges → count 0, issue_valid 0, all outputs 0 immediately; fetch_ready 1 after release.
- Branch: push 0xFE208EE3 (beq x1,x2,-4) at pc 0x100 with issue_ready 1 → after 2 edges: op_type 1100011, op_sub 0, rs1 1, rs2 2, imm 0xFFFFFFFC, writes_rd 0, pc 0x100.
- Shift/jump: push 0x40335293 then 0x008000EF → first presented: rd 5, rs1 6, op_sub 101, imm 3, op_flag 1. Second presented: rd 1, imm 8, use_rs1 0.
- Backpressure (DEPTH=4): issue_ready 0, push continuously → 5 accepted, count 4, fetch_ready 0, outputs frozen. Then issue_ready 1 → entries drain in order, one per cycle.
- Illegal: push 0x0000007F and 0x02001013 (slli with funct7 1) → illegal 1 on both; the first has all fields except op_type equal to 0.
- Flush: queue full plus a presented entry, assert flush with fetch_valid 1 → next cycle count 0, issue_valid 0, and the pushed instruction never appears.
